// File: rtl/spi_target_rx.sv
// SPI mode-0 target receiver: oversamples sclk/cs_n/mosi in the clk domain and
// deserialises MSB-first frames, pulsing rx_valid on good frames and frame_err on bad ones.
module spi_target_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise_q, cs_rise_q, cs_fall_q, mosi_q;
    logic                   armed, overrun;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  shreg;

    logic valid_set, err_set, shift_en, cnt_clr, ovr_set;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign busy   = (state != IDLE);

    // All three pins share the same pipeline depth, and the edge strobes are
    // registered together with mosi so data and clock edges stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync   <= '0;
            cs_sync     <= '0;
            mosi_sync   <= '0;
            sclk_d      <= 1'b0;
            cs_d        <= 1'b0;
            sclk_rise_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
            armed       <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d      <= sclk_s;
            cs_d        <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_d;
            cs_rise_q   <= cs_s & ~cs_d;
            cs_fall_q   <= ~cs_s & cs_d;
            mosi_q      <= mosi_s;
            if (cs_s) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // cs_rise is tested before sclk_rise so a coincident clock edge is discarded.
    always_comb begin
        state_next = state;
        valid_set  = 1'b0;
        err_set    = 1'b0;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall_q && armed) begin
                    state_next = ACTIVE;
                    cnt_clr    = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise_q) begin
                    state_next = IDLE;
                    err_set    = (bit_cnt != '0);
                end else if (sclk_rise_q) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_next = FULL;
                end
            end
            FULL: begin
                if (cs_rise_q) begin
                    state_next = IDLE;
                    err_set    = overrun;
                    valid_set  = ~overrun;
                end else if (sclk_rise_q) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            overrun   <= 1'b0;
        end else begin
            rx_valid  <= valid_set;
            frame_err <= err_set;
            if (valid_set) rx_data <= shreg;
            if (cnt_clr) begin
                bit_cnt <= '0;
                overrun <= 1'b0;
            end else if (shift_en) begin
                shreg   <= {shreg[DATA_WIDTH-2:0], mosi_q};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (ovr_set) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_target_rx.sv
// Directed bench for spi_target_rx: drives SPI frames at 6.25 MHz against a 100 MHz clk
// and checks pulses, latency, data and busy against hand-computed values.
module tb_spi_target_rx;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];

    spi_target_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One frame of nbits bits (MSB first); rst_after>0 pulses rst after that many bits.
    // After cs_n rises, a bounded window of 12 clk cycles counts the result pulses.
    task automatic send_frame(input logic [31:0] data, input int nbits, input int rst_after,
                              output int n_valid, output int n_err, output int n_both,
                              output int lat, output logic busy_mid);
        @(negedge clk);
        busy_mid = 1'b0;
        cs_n = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            mosi = data[nbits-1-i];
            #80 sclk = 1'b1;
            #80 sclk = 1'b0;
            if (i == 0) busy_mid = busy;
            if (rst_after > 0 && i + 1 == rst_after) begin
                rst = 1'b1;
                #30 rst = 1'b0;
            end
        end
        #80 cs_n = 1'b1;
        n_valid = 0;
        n_err   = 0;
        n_both  = 0;
        lat     = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_valid) n_valid++;
            if (frame_err) n_err++;
            if (rx_valid && frame_err) n_both++;
            if ((rx_valid || frame_err) && lat < 0) lat = i;
        end
        #200;
    endtask

    int          nv, ne, nb, lat;
    logic        bm;
    logic [15:0] exp_word;
    logic [15:0] words[3];

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", rx_data, 16'h0000);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Nominal frame
        send_frame(32'hA55A, 16, 0, nv, ne, nb, lat, bm);
        check("nom_busy_mid", bm, 1'b1);
        check("nom_valid_cnt", nv, 1);
        check("nom_err_cnt", ne, 0);
        check("nom_latency_2to4", (lat >= 2 && lat <= 4), 1'b1);
        check("nom_rx_data", rx_data, 16'hA55A);
        check("nom_busy_after", busy, 1'b0);

        // Back-to-back frames
        words[0] = 16'h0000;
        words[1] = 16'hFFFF;
        words[2] = 16'h8001;
        foreach (words[k]) exp_q.push_back(words[k]);
        foreach (words[k]) begin
            send_frame({16'h0, words[k]}, 16, 0, nv, ne, nb, lat, bm);
            exp_word = exp_q.pop_front();
            check("b2b_valid_cnt", nv, 1);
            check("b2b_err_cnt", ne, 0);
            check("b2b_rx_data", rx_data, exp_word);
            check("b2b_busy_gap", busy, 1'b0);
        end

        // Short frame: 9 bits
        send_frame(32'h1FF, 9, 0, nv, ne, nb, lat, bm);
        check("short_err_cnt", ne, 1);
        check("short_valid_cnt", nv, 0);
        check("short_rx_data", rx_data, 16'h8001);
        check("short_latency_2to4", (lat >= 2 && lat <= 4), 1'b1);

        // Overrun frame: 17 bits
        send_frame(32'h1_2345, 17, 0, nv, ne, nb, lat, bm);
        check("ovr_err_cnt", ne, 1);
        check("ovr_valid_cnt", nv, 0);
        check("ovr_both", nb, 0);
        check("ovr_rx_data", rx_data, 16'h8001);

        // Glitch: cs_n low for 5 clk, no sclk
        @(negedge clk);
        cs_n = 1'b0;
        #50 cs_n = 1'b1;
        nv = 0;
        ne = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_valid) nv++;
            if (frame_err) ne++;
        end
        check("glitch_valid_cnt", nv, 0);
        check("glitch_err_cnt", ne, 0);
        check("glitch_busy", busy, 1'b0);
        #200;

        // Reset after bit 6 with cs_n held low, then a clean frame
        send_frame(32'h1234, 16, 6, nv, ne, nb, lat, bm);
        check("rstmid_valid_cnt", nv, 0);
        check("rstmid_err_cnt", ne, 0);
        check("rstmid_rx_data", rx_data, 16'h0000);
        send_frame(32'h00C3, 16, 0, nv, ne, nb, lat, bm);
        check("after_rst_valid_cnt", nv, 1);
        check("after_rst_err_cnt", ne, 0);
        check("after_rst_rx_data", rx_data, 16'h00C3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_target_rx.md
Name: spi_target_rx

Overview:
- SPI target-side receiver: the receiving end of the PMD901 speed link driven by the SPI controller.
- Oversamples the sclk/cs_n/mosi pins in the system clock domain and deserialises 16-bit MSB-first frames.
- Reports each complete frame as a one-cycle valid pulse and flags malformed frames.
- Used as the motor-side model in the bench and as the front end of a future PMD901 target block.

Parameters:
- DATA_WIDTH, 16, bits per frame; must be 2 to 64.
- SYNC_STAGES, 2, flip-flop stages on each input pin; must be at least 2.

Ports:
- clk  input  1  system clock; frequency must be at least 4x the sclk frequency.
- rst  input  1  reset; synchronous, active-high.
- sclk  input  1  SPI clock pin, asynchronous to clk; idles low.
- cs_n  input  1  SPI chip select pin, asynchronous to clk; active-low.
- mosi  input  1  SPI data pin, asynchronous to clk.
- rx_data  output  DATA_WIDTH  last correctly received frame.
- rx_valid  output  1  one-cycle pulse; rx_data is updated in the same cycle.
- frame_err  output  1  one-cycle pulse on a malformed frame.
- busy  output  1  high while a frame is in progress (state ACTIVE or FULL).

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, armed=0, bit_cnt=0, shift register=0.
- Synchronisers:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops, so the three pins stay mutually aligned.
  - sclk_rise = synchronised sclk high while its registered copy is low.
  - cs_rise and cs_fall are formed the same way from synchronised cs_n.
- Sampling: mode 0. Synchronised mosi is shifted in on sclk_rise, MSB first, as shreg <= {shreg[W-2:0], mosi}. Falling sclk edges are ignored.
- armed flag:
  - Set when synchronised cs_n is seen high.
  - Cleared by rst.
  - A cs_fall while armed=0 is ignored. This covers a reset released mid-frame.
- FSM states:
  - IDLE: on cs_fall with armed=1, clear bit_cnt, go to ACTIVE, busy=1.
  - ACTIVE:
    - Each sclk_rise shifts one bit and increments bit_cnt.
    - When bit_cnt reaches DATA_WIDTH, go to FULL.
    - On cs_rise with bit_cnt=0, return to IDLE with no pulse (glitch, silently dropped).
    - On cs_rise with 0<bit_cnt<DATA_WIDTH, pulse frame_err and return to IDLE.
  - FULL:
    - Any further sclk_rise sets an overrun flag; the shift register is frozen.
    - On cs_rise with no overrun: rx_data<=shreg, rx_valid=1 for one cycle, go to IDLE.
    - On cs_rise with overrun: frame_err=1 for one cycle, rx_data unchanged, go to IDLE.
- Simultaneous events:
  - If sclk_rise and cs_rise occur in the same cycle, cs_rise wins and the edge is discarded.
  - rx_valid and frame_err are never high together.
- Latency:
  - rx_valid or frame_err asserts exactly SYNC_STAGES+1 clk cycles after the pin-level cs_n rise is first captured.
  - Jitter is 1 cycle, due to the asynchronous capture.
- busy drops in the same cycle as the rx_valid or frame_err pulse.
- rx_data holds its value until the next valid frame; it is not cleared by error frames.
- Reset mid-frame:
  - Partial data is discarded and no pulse is issued.
  - The next frame is accepted only after cs_n has been seen high.

Test Plan:
- Nominal frame:
  - Stimulus: clk 100 MHz, sclk 6.25 MHz, cs_n low, word 16'hA55A sent MSB-first, cs_n high.
  - Required response: rx_valid single pulse 3 clk (±1) after the cs_n rise, rx_data=16'hA55A, frame_err=0.
- Back-to-back frames:
  - Stimulus: 16'h0000, 16'hFFFF, 16'h8001, with 2 sclk periods of cs_n high between them.
  - Required response: three rx_valid pulses with matching rx_data, and busy low between frames.
- Short frame:
  - Stimulus: 9 bits, then cs_n rises.
  - Required response: frame_err pulse, no rx_valid, rx_data keeps the previous value.
- Overrun frame:
  - Stimulus: 17 sclk edges.
  - Required response: frame_err pulse, rx_data unchanged.
- Glitch frame:
  - Stimulus: cs_n low 5 clk with no sclk edges.
  - Required response: no rx_valid, no frame_err.
- Reset while cs_n low:
  - Stimulus: assert rst after bit 6, release it with cs_n still low, finish the frame with 16'h1234, then send 16'h00C3 as a clean frame.
  - Required response: the first frame is ignored, then one rx_valid with rx_data=16'h00C3.
